// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline register with valid bit, stall/flush control, registered branch decision
// and saturating stall/bubble counters. Define EXMEM_FWD_EN to add the FwdA/FwdB match outputs.
module ex_mem_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MEM_CTRL_W = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  CntClear,
    input  logic                  InValid,
    input  logic                  RegWrite,
    input  logic                  Branch,
    input  logic                  MemToReg,
    input  logic                  Jal,
    input  logic                  Zero,
    input  logic [MEM_CTRL_W-1:0] MemWrite,
    input  logic [MEM_CTRL_W-1:0] MemRead,
    input  logic [DATA_W-1:0]     RData2,
    input  logic [DATA_W-1:0]     ALUResult,
    input  logic [DATA_W-1:0]     PCAddResult,
    input  logic [DATA_W-1:0]     BranchPC,
    input  logic [REG_ADDR_W-1:0] RdReg,
`ifdef EXMEM_FWD_EN
    input  logic [REG_ADDR_W-1:0] RsEx,
    input  logic [REG_ADDR_W-1:0] RtEx,
    output logic                  FwdA,
    output logic                  FwdB,
`endif
    output logic                  OutValid,
    output logic                  RegWriteOut,
    output logic                  BranchOut,
    output logic                  MemToRegOut,
    output logic                  JalOut,
    output logic                  ZeroOut,
    output logic [MEM_CTRL_W-1:0] MemWriteOut,
    output logic [MEM_CTRL_W-1:0] MemReadOut,
    output logic [DATA_W-1:0]     RData2Out,
    output logic [DATA_W-1:0]     ALUResultOut,
    output logic [DATA_W-1:0]     PCAddResultOut,
    output logic [DATA_W-1:0]     BranchPCOut,
    output logic [REG_ADDR_W-1:0] RdRegOut,
    output logic                  PCSrcOut,
    output logic [CNT_W-1:0]      StallCount,
    output logic [CNT_W-1:0]      BubbleCount
);

    logic                  r_valid;
    logic                  r_regwrite;
    logic                  r_branch;
    logic                  r_memtoreg;
    logic                  r_jal;
    logic                  r_zero;
    logic                  r_pcsrc;
    logic [MEM_CTRL_W-1:0] r_memwrite;
    logic [MEM_CTRL_W-1:0] r_memread;
    logic [DATA_W-1:0]     r_rdata2;
    logic [DATA_W-1:0]     r_alu;
    logic [DATA_W-1:0]     r_pcadd;
    logic [DATA_W-1:0]     r_brpc;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_bubble_cnt;

    logic w_stall_eff;
    logic w_bubble;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_stall_eff = Stall & ~Flush;
    // A bubble is any edge that writes OutValid=0: a flush, or a load of an empty slot.
    assign w_bubble    = Flush | (~Stall & ~InValid);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_branch   <= 1'b0;
            r_memtoreg <= 1'b0;
            r_jal      <= 1'b0;
            r_zero     <= 1'b0;
            r_pcsrc    <= 1'b0;
            r_memwrite <= '0;
            r_memread  <= '0;
            r_rdata2   <= '0;
            r_alu      <= '0;
            r_pcadd    <= '0;
            r_brpc     <= '0;
            r_rd       <= '0;
        end else if (Flush) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_branch   <= 1'b0;
            r_memtoreg <= 1'b0;
            r_jal      <= 1'b0;
            r_zero     <= 1'b0;
            r_pcsrc    <= 1'b0;
            r_memwrite <= '0;
            r_memread  <= '0;
            r_rdata2   <= '0;
            r_alu      <= '0;
            r_pcadd    <= '0;
            r_brpc     <= '0;
            r_rd       <= '0;
        end else if (!Stall) begin
            // Controls are masked by InValid so an empty slot can never write or branch.
            r_valid    <= InValid;
            r_regwrite <= RegWrite & InValid;
            r_branch   <= Branch & InValid;
            r_memtoreg <= MemToReg & InValid;
            r_jal      <= Jal & InValid;
            r_zero     <= Zero & InValid;
            r_pcsrc    <= Branch & Zero & InValid;
            r_memwrite <= InValid ? MemWrite : '0;
            r_memread  <= InValid ? MemRead : '0;
            r_rdata2   <= RData2;
            r_alu      <= ALUResult;
            r_pcadd    <= PCAddResult;
            r_brpc     <= BranchPC;
            r_rd       <= RdReg;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else if (CntClear) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_stall_eff) r_stall_cnt  <= sat_inc(r_stall_cnt);
            if (w_bubble)    r_bubble_cnt <= sat_inc(r_bubble_cnt);
        end
    end

    assign OutValid       = r_valid;
    assign RegWriteOut    = r_regwrite;
    assign BranchOut      = r_branch;
    assign MemToRegOut    = r_memtoreg;
    assign JalOut         = r_jal;
    assign ZeroOut        = r_zero;
    assign PCSrcOut       = r_pcsrc;
    assign MemWriteOut    = r_memwrite;
    assign MemReadOut     = r_memread;
    assign RData2Out      = r_rdata2;
    assign ALUResultOut   = r_alu;
    assign PCAddResultOut = r_pcadd;
    assign BranchPCOut    = r_brpc;
    assign RdRegOut       = r_rd;
    assign StallCount     = r_stall_cnt;
    assign BubbleCount    = r_bubble_cnt;

`ifdef EXMEM_FWD_EN
    // Loads (MemToReg) are excluded: their result is not available until after MEM.
    assign FwdA = r_valid & r_regwrite & ~r_memtoreg & (r_rd != '0) & (r_rd == RsEx);
    assign FwdB = r_valid & r_regwrite & ~r_memtoreg & (r_rd != '0) & (r_rd == RtEx);
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Directed bench for ex_mem_stage_reg: a default-width instance plus a CNT_W=2 instance
// sharing the same inputs to exercise counter saturation.
module tb_ex_mem_stage_reg;

    logic        Clk = 1'b0;
    logic        Reset, Stall, Flush, CntClear, InValid;
    logic        RegWrite, Branch, MemToReg, Jal, Zero;
    logic [1:0]  MemWrite, MemRead;
    logic [31:0] RData2, ALUResult, PCAddResult, BranchPC;
    logic [4:0]  RdReg;

    logic        OutValid, RegWriteOut, BranchOut, MemToRegOut, JalOut, ZeroOut, PCSrcOut;
    logic [1:0]  MemWriteOut, MemReadOut;
    logic [31:0] RData2Out, ALUResultOut, PCAddResultOut, BranchPCOut;
    logic [4:0]  RdRegOut;
    logic [15:0] StallCount, BubbleCount;

    logic        s_OutValid, s_RegWriteOut, s_BranchOut, s_MemToRegOut, s_JalOut, s_ZeroOut, s_PCSrcOut;
    logic [1:0]  s_MemWriteOut, s_MemReadOut;
    logic [31:0] s_RData2Out, s_ALUResultOut, s_PCAddResultOut, s_BranchPCOut;
    logic [4:0]  s_RdRegOut;
    logic [1:0]  s_StallCount, s_BubbleCount;

`ifdef EXMEM_FWD_EN
    logic [4:0] RsEx = 5'd0, RtEx = 5'd0;
    logic       FwdA, FwdB, s_FwdA, s_FwdB;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 Clk = ~Clk;

    ex_mem_stage_reg dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .CntClear(CntClear),
        .InValid(InValid), .RegWrite(RegWrite), .Branch(Branch), .MemToReg(MemToReg),
        .Jal(Jal), .Zero(Zero), .MemWrite(MemWrite), .MemRead(MemRead),
        .RData2(RData2), .ALUResult(ALUResult), .PCAddResult(PCAddResult),
        .BranchPC(BranchPC), .RdReg(RdReg),
`ifdef EXMEM_FWD_EN
        .RsEx(RsEx), .RtEx(RtEx), .FwdA(FwdA), .FwdB(FwdB),
`endif
        .OutValid(OutValid), .RegWriteOut(RegWriteOut), .BranchOut(BranchOut),
        .MemToRegOut(MemToRegOut), .JalOut(JalOut), .ZeroOut(ZeroOut),
        .MemWriteOut(MemWriteOut), .MemReadOut(MemReadOut), .RData2Out(RData2Out),
        .ALUResultOut(ALUResultOut), .PCAddResultOut(PCAddResultOut),
        .BranchPCOut(BranchPCOut), .RdRegOut(RdRegOut), .PCSrcOut(PCSrcOut),
        .StallCount(StallCount), .BubbleCount(BubbleCount)
    );

    ex_mem_stage_reg #(.CNT_W(2)) dut_s (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .CntClear(CntClear),
        .InValid(InValid), .RegWrite(RegWrite), .Branch(Branch), .MemToReg(MemToReg),
        .Jal(Jal), .Zero(Zero), .MemWrite(MemWrite), .MemRead(MemRead),
        .RData2(RData2), .ALUResult(ALUResult), .PCAddResult(PCAddResult),
        .BranchPC(BranchPC), .RdReg(RdReg),
`ifdef EXMEM_FWD_EN
        .RsEx(RsEx), .RtEx(RtEx), .FwdA(s_FwdA), .FwdB(s_FwdB),
`endif
        .OutValid(s_OutValid), .RegWriteOut(s_RegWriteOut), .BranchOut(s_BranchOut),
        .MemToRegOut(s_MemToRegOut), .JalOut(s_JalOut), .ZeroOut(s_ZeroOut),
        .MemWriteOut(s_MemWriteOut), .MemReadOut(s_MemReadOut), .RData2Out(s_RData2Out),
        .ALUResultOut(s_ALUResultOut), .PCAddResultOut(s_PCAddResultOut),
        .BranchPCOut(s_BranchPCOut), .RdRegOut(s_RdRegOut), .PCSrcOut(s_PCSrcOut),
        .StallCount(s_StallCount), .BubbleCount(s_BubbleCount)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Stall = 0; Flush = 0; CntClear = 0; InValid = 0;
        RegWrite = 0; Branch = 0; MemToReg = 0; Jal = 0; Zero = 0;
        MemWrite = '0; MemRead = '0;
        RData2 = '0; ALUResult = '0; PCAddResult = '0; BranchPC = '0; RdReg = '0;
    endtask

    task automatic all_ones();
        Stall = 1; Flush = 1; CntClear = 1; InValid = 1;
        RegWrite = 1; Branch = 1; MemToReg = 1; Jal = 1; Zero = 1;
        MemWrite = '1; MemRead = '1;
        RData2 = '1; ALUResult = '1; PCAddResult = '1; BranchPC = '1; RdReg = '1;
    endtask

    initial begin
        idle();
        Reset = 1;
        #12 Reset = 0;

        // Fill the stage with all-ones, then pulse reset mid-cycle.
        all_ones();
        Stall = 0; Flush = 0; CntClear = 0;
        tick();
        tick();
        chk("pre_rst_valid", {31'd0, OutValid}, 32'd1);
        chk("pre_rst_alu", ALUResultOut, 32'hFFFF_FFFF);
        all_ones();
        #3 Reset = 1;
        #1;
        chk("rst_valid", {31'd0, OutValid}, 32'd0);
        chk("rst_regwrite", {31'd0, RegWriteOut}, 32'd0);
        chk("rst_pcsrc", {31'd0, PCSrcOut}, 32'd0);
        chk("rst_memwrite", {30'd0, MemWriteOut}, 32'd0);
        chk("rst_alu", ALUResultOut, 32'd0);
        chk("rst_rd", {27'd0, RdRegOut}, 32'd0);
        chk("rst_stallcnt", {16'd0, StallCount}, 32'd0);
        chk("rst_bubblecnt", {16'd0, BubbleCount}, 32'd0);
        Reset = 0;

        // Basic load, counters cleared on the same edge.
        idle();
        InValid = 1; RegWrite = 1; RdReg = 5'd5; ALUResult = 32'h1234; CntClear = 1;
        tick();
        CntClear = 0;
        chk("ld_valid", {31'd0, OutValid}, 32'd1);
        chk("ld_regwrite", {31'd0, RegWriteOut}, 32'd1);
        chk("ld_rd", {27'd0, RdRegOut}, 32'd5);
        chk("ld_alu", ALUResultOut, 32'h1234);
        chk("ld_bubblecnt", {16'd0, BubbleCount}, 32'd0);

        // Three stalled edges while the inputs keep changing.
        Stall = 1; RegWrite = 0; RdReg = 5'd7;
        for (int i = 0; i < 3; i++) begin
            ALUResult = 32'hAAAA + i;
            tick();
        end
        chk("stl_alu", ALUResultOut, 32'h1234);
        chk("stl_rd", {27'd0, RdRegOut}, 32'd5);
        chk("stl_regwrite", {31'd0, RegWriteOut}, 32'd1);
        chk("stl_stallcnt", {16'd0, StallCount}, 32'd3);
        chk("stl_bubblecnt", {16'd0, BubbleCount}, 32'd0);

        // Flush beats stall.
        Stall = 1; Flush = 1; InValid = 1; MemWrite = 2'd2; Branch = 1; Zero = 1;
        tick();
        chk("fl_valid", {31'd0, OutValid}, 32'd0);
        chk("fl_memwrite", {30'd0, MemWriteOut}, 32'd0);
        chk("fl_pcsrc", {31'd0, PCSrcOut}, 32'd0);
        chk("fl_alu", ALUResultOut, 32'd0);
        chk("fl_rd", {27'd0, RdRegOut}, 32'd0);
        chk("fl_bubblecnt", {16'd0, BubbleCount}, 32'd1);
        chk("fl_stallcnt", {16'd0, StallCount}, 32'd3);

        // Taken branch with a valid slot.
        idle();
        InValid = 1; Branch = 1; Zero = 1; BranchPC = 32'h400; MemRead = 2'd1;
        MemToReg = 1; Jal = 1; PCAddResult = 32'h8; RData2 = 32'hBEEF;
        tick();
        chk("br_pcsrc", {31'd0, PCSrcOut}, 32'd1);
        chk("br_branch", {31'd0, BranchOut}, 32'd1);
        chk("br_zero", {31'd0, ZeroOut}, 32'd1);
        chk("br_pc", BranchPCOut, 32'h400);
        chk("br_memread", {30'd0, MemReadOut}, 32'd1);
        chk("br_memtoreg", {31'd0, MemToRegOut}, 32'd1);
        chk("br_jal", {31'd0, JalOut}, 32'd1);
        chk("br_pcadd", PCAddResultOut, 32'h8);
        chk("br_rdata2", RData2Out, 32'hBEEF);

        // Same branch inputs with an empty slot: controls masked, data still captured.
        InValid = 0; RegWrite = 1; MemWrite = 2'd3; BranchPC = 32'h500;
        tick();
        chk("inv_pcsrc", {31'd0, PCSrcOut}, 32'd0);
        chk("inv_branch", {31'd0, BranchOut}, 32'd0);
        chk("inv_valid", {31'd0, OutValid}, 32'd0);
        chk("inv_regwrite", {31'd0, RegWriteOut}, 32'd0);
        chk("inv_memwrite", {30'd0, MemWriteOut}, 32'd0);
        chk("inv_memread", {30'd0, MemReadOut}, 32'd0);
        chk("inv_jal", {31'd0, JalOut}, 32'd0);
        chk("inv_pc", BranchPCOut, 32'h500);
        chk("inv_bubblecnt", {16'd0, BubbleCount}, 32'd2);

        // Saturation on the 2-bit instance.
        idle();
        InValid = 1; ALUResult = 32'h77; CntClear = 1;
        tick();
        CntClear = 0;
        chk("clr_s_stallcnt", {30'd0, s_StallCount}, 32'd0);
        Stall = 1; ALUResult = 32'h99;
        for (int i = 0; i < 5; i++) tick();
        chk("sat_s_stallcnt", {30'd0, s_StallCount}, 32'd3);
        chk("sat_stallcnt", {16'd0, StallCount}, 32'd5);
        CntClear = 1;
        tick();
        CntClear = 0;
        chk("clrstl_s_stallcnt", {30'd0, s_StallCount}, 32'd0);
        chk("clrstl_stallcnt", {16'd0, StallCount}, 32'd0);
        chk("clrstl_alu", ALUResultOut, 32'h77);
        chk("clrstl_valid", {31'd0, OutValid}, 32'd1);

        Stall = 0; InValid = 0;
        for (int i = 0; i < 5; i++) tick();
        chk("sat_s_bubblecnt", {30'd0, s_BubbleCount}, 32'd3);
        chk("sat_bubblecnt", {16'd0, BubbleCount}, 32'd5);

        // First edge after reset release behaves normally.
        #3 Reset = 1;
        InValid = 1; RegWrite = 1; RdReg = 5'd9;
        #1 Reset = 0;
        tick();
        chk("rel_valid", {31'd0, OutValid}, 32'd1);
        chk("rel_rd", {27'd0, RdRegOut}, 32'd9);
        chk("rel_bubblecnt", {16'd0, BubbleCount}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
